// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one sync FIFO write port among NUM_REQ producers.
// Per-producer accepted-beat counters are built only when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(MAX_BURST) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_write_en,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  input  logic [IW-1:0]                 stat_sel,
  output logic [15:0]                   stat_count
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_next;
  logic [IW-1:0] last_grant, winner, cand;
  logic [BW-1:0] beat_cnt;
  logic found, any_req, cur_valid, cur_last, accept, burst_end, release_grant;
  always_comb begin
    winner = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found = 1'b1;
      end
    end
  end
  assign any_req = |req_valid;
  assign cur_valid = req_valid[grant_id];
  assign cur_last = req_last[grant_id];
  assign burst_end = cur_last || (beat_cnt + BW'(1) == BW'(MAX_BURST));
  // a stalled grant (fifo_full) holds everything, even if valid were to drop
  assign release_grant = state == GRANT && !fifo_full && (!cur_valid || burst_end);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_comb
    state_next = (state == IDLE) ? (any_req ? GRANT : IDLE) : (release_grant ? IDLE : GRANT);
  always_comb begin
    busy = !reset && state == GRANT;
    accept = busy && cur_valid && !fifo_full;
    fifo_write_en = accept;
    fifo_din = busy ? req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
    req_ready = '0;
    if (busy) req_ready[grant_id] = !fifo_full;
  end
  always_ff @(posedge clk)
    if (reset) begin
      grant_id <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_id <= winner;
        beat_cnt <= '0;
      end else if (accept) beat_cnt <= beat_cnt + BW'(1);
      if (release_grant) last_grant <= grant_id;
    end
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    else if (accept && cnt[grant_id] != 16'hFFFF) cnt[grant_id] <= cnt[grant_id] + 16'd1;
  assign stat_count = (!reset && int'(stat_sel) < NUM_REQ) ? cnt[stat_sel] : '0;
`else
  logic unused_sel;
  assign unused_sel = ^stat_sel;
  assign stat_count = '0;
`endif
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed self-checking bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_fifo_write_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic fifo_full = 1'b0;
  logic [N-1:0] req_ready;
  logic [DW-1:0] fifo_din;
  logic fifo_write_en;
  logic [1:0] grant_id;
  logic busy;
  logic [1:0] stat_sel = '0;
  logic [15:0] stat_count;
  int n_cmp = 0;
  int n_bad = 0;

  fifo_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_din(fifo_din), .fifo_write_en(fifo_write_en), .grant_id(grant_id),
    .busy(busy), .stat_sel(stat_sel), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    fifo_full = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic run_beats(input int idx, input int n);
    int got;
    got = 0;
    req_valid = N'(1) << idx;
    for (int t = 0; t < 4*n + 4 && got < n; t++) begin
      req_last = (got == n - 1) ? (N'(1) << idx) : '0;
      @(negedge clk);
      if (fifo_write_en) got++;
      cyc();
    end
    req_valid = '0;
    req_last = '0;
    chk("stat_beats", got, n);
  endtask

  initial begin
    int beats;
    // reset state
    cyc();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_we", fifo_write_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_stat", stat_count, 0);
    cyc();
    reset = 1'b0;

    // single producer 0, four beats ending on last
    req_valid = 4'b0001;
    set_data(0, 32'hA0);
    @(negedge clk);
    chk("t1_bubble_we", fifo_write_en, 0);
    chk("t1_bubble_busy", busy, 0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      set_data(0, 32'hA0 + k);
      req_last = (k == 3) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      chk("t1_we", fifo_write_en, 1);
      chk("t1_din", fifo_din, 32'hA0 + k);
      chk("t1_gid", grant_id, 0);
      chk("t1_ready", req_ready, 4'b0001);
      cyc();
    end
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    chk("t1_end_busy", busy, 0);
    chk("t1_end_we", fifo_write_en, 0);
    cyc();

    // all producers valid: 0,1,2,3,0 in bursts of 4 with one bubble each
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < N; i++) set_data(i, 32'hB0 + i);
    beats = 0;
    for (int t = 0; t < 22; t++) begin
      @(negedge clk);
      if (t < 20 && fifo_write_en) beats++;
      if (t % 5 == 0) begin
        chk("t2_idle_we", fifo_write_en, 0);
        chk("t2_idle_busy", busy, 0);
      end else begin
        chk("t2_we", fifo_write_en, 1);
        chk("t2_gid", grant_id, (t / 5) % 4);
        chk("t2_din", fifo_din, 32'hB0 + (t / 5) % 4);
      end
      cyc();
    end
    chk("t2_beats", beats, 16);

    // producer 2 stalled by fifo_full for 3 cycles mid-burst
    do_reset();
    req_valid = 4'b0100;
    set_data(2, 32'hC0);
    beats = 0;
    @(negedge clk);
    chk("t3_bubble", busy, 0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      set_data(2, 32'hC0 + k);
      @(negedge clk);
      if (fifo_write_en) beats++;
      chk("t3_din_pre", fifo_din, 32'hC0 + k);
      cyc();
    end
    set_data(2, 32'hC2);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (fifo_write_en) beats++;
      chk("t3_full_ready", req_ready, 0);
      chk("t3_full_we", fifo_write_en, 0);
      chk("t3_full_busy", busy, 1);
      chk("t3_full_gid", grant_id, 2);
      cyc();
    end
    fifo_full = 1'b0;
    for (int k = 2; k < 4; k++) begin
      set_data(2, 32'hC0 + k);
      @(negedge clk);
      if (fifo_write_en) beats++;
      chk("t3_din_post", fifo_din, 32'hC0 + k);
      chk("t3_ready_post", req_ready, 4'b0100);
      cyc();
    end
    @(negedge clk);
    chk("t3_burst_done", busy, 0);
    chk("t3_beats", beats, 4);
    req_valid = '0;
    cyc();

    // producer 1 drops valid after 2 beats while producer 3 waits
    do_reset();
    set_data(1, 32'hD1);
    set_data(3, 32'hD3);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t4_bubble", busy, 0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t4_p1_gid", grant_id, 1);
      chk("t4_p1_we", fifo_write_en, 1);
      cyc();
    end
    req_valid = 4'b1000;
    @(negedge clk);
    chk("t4_drop_we", fifo_write_en, 0);
    chk("t4_drop_busy", busy, 1);
    cyc();
    req_valid = 4'b1010;
    req_last = 4'b1000;
    @(negedge clk);
    chk("t4_release", busy, 0);
    cyc();
    @(negedge clk);
    chk("t4_p3_gid", grant_id, 3);
    chk("t4_p3_we", fifo_write_en, 1);
    chk("t4_p3_din", fifo_din, 32'hD3);
    chk("t4_p3_ready", req_ready, 4'b1000);
    cyc();
    @(negedge clk);
    chk("t4_p3_done", busy, 0);
    cyc();
    @(negedge clk);
    chk("t4_p1_again", grant_id, 1);
    chk("t4_p1_din", fifo_din, 32'hD1);
    req_valid = '0;
    req_last = '0;
    cyc();

    // reset on the second beat of producer 1
    do_reset();
    set_data(1, 32'hE1);
    req_valid = 4'b0010;
    cyc();
    @(negedge clk);
    chk("t5_beat1", fifo_write_en, 1);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_we", fifo_write_en, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_busy", busy, 0);
    cyc();
    reset = 1'b0;
    req_valid = 4'hF;
    set_data(0, 32'hE0);
    @(negedge clk);
    chk("t5_idle", busy, 0);
    cyc();
    @(negedge clk);
    chk("t5_gid", grant_id, 0);
    chk("t5_din", fifo_din, 32'hE0);
    req_valid = '0;
    cyc();

    // statistics counters
    do_reset();
    run_beats(0, 5);
    run_beats(3, 3);
    stat_sel = 2'd0;
    #1;
`ifdef FIFO_ARB_STATS_EN
    chk("stat0", stat_count, 5);
    stat_sel = 2'd3;
    #1;
    chk("stat3", stat_count, 3);
    stat_sel = 2'd1;
    #1;
    chk("stat1", stat_count, 0);
`else
    chk("stat0", stat_count, 0);
    stat_sel = 2'd3;
    #1;
    chk("stat3", stat_count, 0);
    stat_sel = 2'd1;
    #1;
    chk("stat1", stat_count, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the write port of one synchronous FIFO among NUM_REQ producers.
- Grants the write port round-robin, in bursts of up to MAX_BURST beats or until the producer marks its last beat.
- Drives the FIFO's din/write_en directly and backpressures producers from the FIFO's full flag.
- Sits between producer blocks and the sync FIFO instance.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- DATA_WIDTH, 32, data word width; must match the FIFO.
- MAX_BURST, 4, maximum beats per grant (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i: producer i has a beat on its data slice.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  bit i: current beat of producer i ends its burst.
- req_ready  output  NUM_REQ  bit i: beat of producer i accepted this cycle when valid is also high.
- fifo_full  input  1  FIFO full flag.
- fifo_din  output  DATA_WIDTH  FIFO write data.
- fifo_write_en  output  1  FIFO write strobe.
- grant_id  output  max(1,$clog2(NUM_REQ))  index of the current or most recent grantee.
- busy  output  1  high in GRANT state.
- stat_sel  input  max(1,$clog2(NUM_REQ))  statistics counter select.
- stat_count  output  16  selected statistics counter.

Behaviour:
- FSM states: IDLE, GRANT.
- Registers:
  - grant_id.
  - last_grant.
  - beat_cnt, width $clog2(MAX_BURST)+1.
- Reset values:
  - state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (so producer 0 has first priority), beat_cnt=0.
  - req_ready=0, fifo_write_en=0, busy=0, stat_count=0.
- IDLE:
  - If any req_valid is high, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register the winner into grant_id, clear beat_cnt, go to GRANT next cycle.
  - This costs one arbitration bubble; no beat is accepted in IDLE.
- GRANT:
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - Combinational outputs: fifo_write_en = req_valid[grant_id] && !fifo_full; fifo_din = data slice of grant_id.
  - Zero-cycle path: the FIFO samples the beat on the same edge the producer sees the handshake.
- Accepted beat (fifo_write_en=1): beat_cnt increments.
  - If req_last[grant_id]=1 or beat_cnt+1 == MAX_BURST, set last_grant=grant_id and go to IDLE.
- fifo_full high in GRANT: no beat is accepted. State, beat_cnt and grant are held. The producer must hold data, valid and last stable.
- req_valid[grant_id] low in GRANT (no beat): release the grant. Set last_grant=grant_id and go to IDLE. A partial burst counts as complete.
- Single active requester: it is regranted after each burst with a 1-cycle bubble between bursts.
- Requests arriving during GRANT do not preempt the grant; they are considered at the next IDLE.
- MAX_BURST=1: every grant is exactly one beat, giving strict round-robin per beat.
- The block never asserts fifo_write_en while fifo_full=1 and never writes more than one word per cycle.
- Reset mid-burst: returns to IDLE next cycle. No write occurs in the reset cycle (outputs are forced to 0 while reset is high). last_grant returns to NUM_REQ-1.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - One 16-bit saturating counter per producer, incremented on each accepted beat from that producer.
  - Counters hold at 16'hFFFF and clear on reset.
  - stat_count = counter[stat_sel], combinational.
  - stat_sel >= NUM_REQ returns 0.
- Undefined: no counters are built, stat_count is tied to 0, and stat_sel is ignored.

Test Plan:
- Reset, then req_valid=4'b0001, data 0xA0..0xA3, last on 4th beat, FIFO never full -> grant_id=0 after 1 bubble; fifo_write_en high 4 consecutive cycles with din 0xA0,0xA1,0xA2,0xA3; back to IDLE.
- All 4 producers continuously valid, no last, MAX_BURST=4 -> grant order 0,1,2,3,0; exactly 4 beats per grant; 1 idle cycle between grants; 16 beats in 20 cycles.
- Producer 2 bursting and fifo_full asserted for 3 cycles mid-burst -> req_ready[2]=0 and fifo_write_en=0 for those 3 cycles; beat_cnt held; burst resumes with the same data; total of 4 beats written, none duplicated or lost.
- Producer 1 drops valid after 2 beats while producer 3 is waiting -> grant released; next grant goes to producer 3; producer 1 gets its turn only after producer 3.
- Reset asserted on the 2nd beat of a burst from producer 1 -> no write in the reset cycle; after reset with all producers valid, first grant_id=0.
- With FIFO_ARB_STATS_EN: 5 beats from producer 0 and 3 beats from producer 3 -> stat_sel=0 gives 5, stat_sel=3 gives 3, stat_sel=1 gives 0. Without the macro: stat_count=0 always.
